alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit combinational ALU between two requesters (port 0 = core
//  datapath, port 1 = address/branch unit). Valid/ready request handshake, round-robin
//  grant, operand and op registers driving the ALU, and a registered, held response
//  routed back to the granted requester. Sits between the requesters and the ALU instance.
// PARAMETERS
//  WIDTH   16  operand/result width; must match the ALU
//  OPW     4   ALUop width; codes are the ALU_* constants in constants.v
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  req0_valid   in   1      port 0 request present
//  req0_ready   out  1      port 0 request accepted this cycle
//  req0_a       in   WIDTH  port 0 operand A
//  req0_b       in   WIDTH  port 0 operand B
//  req0_op      in   OPW    port 0 ALUop
//  rsp0_valid   out  1      port 0 result valid
//  rsp0_ready   in   1      port 0 consumes result
//  req1_*/rsp1_* same as port 0, for port 1
//  rsp_result   out  WIDTH  result register, shared; qualified by rsp0/1_valid
//  alu_a        out  WIDTH  to ALU operand A (registered)
//  alu_b        out  WIDTH  to ALU operand B (registered)
//  alu_op       out  OPW    to ALU op (registered)
//  alu_result   in   WIDTH  from ALU output
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, all *_valid/*_ready/busy=0, alu_a/b/rsp_result=0,
//    alu_op=ALU_AND, priority pointer=port 0. Reset mid-operation aborts it; nothing is returned.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: if any reqN_valid, arbiter picks winner; reqN_ready=1 for winner only
//      (combinational, IDLE only); on the edge latch winner's a/b/op into alu_a/b/op,
//      store grant id, flip priority to the other port, -> EXEC. No valid: stay.
//    EXEC: one cycle for ALU settling; latch alu_result into rsp_result -> RESP.
//    RESP: rspN_valid=1 for stored grant id only; rsp_result and valid held stable
//      until rspN_ready=1; then -> IDLE. Other port's rsp_ready ignored.
//  - Latency: accept at edge 0, rspN_valid high after edge 2 (2 cycles). Minimum spacing
//    between accepts: 3 cycles (RESP->IDLE bubble; no accept in RESP).
//  - Arbitration: both valid -> port named by priority pointer wins; single valid wins
//    regardless of pointer. Pointer updates only on an accept.
//  - reqN_ready never asserted outside IDLE; requester must hold valid/a/b/op until ready.
//  - Opcodes passed through unchecked; undefined codes yield whatever the ALU returns.
//  - Arithmetic entirely in the ALU; this block adds no width extension or flags.
// STRUCTURE
//  - constants.v: ALU_* opcodes (existing) plus new ARB_IDLE/ARB_EXEC/ARB_RESP state codes
//    (2-bit).
//  - Sub-module rr_arbiter_2: inputs valid[1:0], priority pointer, enable; outputs one-hot
//    grant and next pointer. FSM, operand registers and response mux in alu_arbiter.
//  - ALU instantiated by the parent, not inside this block.
// TESTING  (bench instantiates alu_arbiter + ALU + ClockGenerator)
//  1 reset low mid-EXEC (port0 ADD 16,101) -> all valids 0, state IDLE,
//    no rsp0_valid after release
//  2 port0 only: AND 15,30 -> req0_ready in cycle 0, rsp0_valid after 2 edges,
//    rsp_result=14
//  3 both valid at once after reset: p0 ADD 16,101, p1 SUB 44,15 -> p0 first (117),
//    then p1 (29); pointer alternates
//  4 backpressure: p1 SUB 44,15, rsp1_ready low 5 cycles -> rsp1_valid and rsp_result=29
//    held; no new grant
//  5 p0 valid continuously, p1 valid continuously -> grants strictly alternate
//    0,1,0,1; spacing 3 cycles
//  6 rsp0_ready pulsed while port1 response pending -> ignored; rsp1 still held

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice: datapath widths, the ALU opcode
// codes the requesters place on reqN_op, and the arbiter FSM state encoding.
// No ports (package).

package alu_arbiter_pkg;

  // Operand/result width and ALUop width; both must match the ALU instance.
  localparam int WIDTH = 16;
  localparam int OPW   = 4;

  // ALU opcodes. The arbiter passes these through untouched; they live here so
  // requesters, the ALU and the arbiter reset value agree on one set of codes.
  localparam logic [OPW-1:0] ALU_AND = 4'd0;
  localparam logic [OPW-1:0] ALU_OR  = 4'd1;
  localparam logic [OPW-1:0] ALU_ADD = 4'd2;
  localparam logic [OPW-1:0] ALU_SUB = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR = 4'd4;

  // Arbiter FSM: accept a request, give the ALU one cycle to settle, then hold
  // the response until the granted requester consumes it.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arbState_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the two requester handshakes, the shared response bus and the ALU
// hookup of the arbiter into one interface.
//   req0_* / req1_*   : request valid/ready plus operands and op, per port
//   rsp0_* / rsp1_*   : response valid/ready, per port
//   rsp_result        : shared result register, qualified by rspN_valid
//   alu_a/alu_b/alu_op: registered operands/op towards the ALU
//   alu_result        : combinational ALU output back to the arbiter
//   busy              : arbiter is not idle
// Modports: slave = arbiter side, master = requester/ALU side.

interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             rsp0_valid;
  logic             rsp0_ready;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp1_valid;
  logic             rsp1_ready;

  logic [WIDTH-1:0] rsp_result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_result, alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_result, alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter_2
// Two-port round-robin picker. Purely combinational.
//   valid_i[1:0] : request present per port
//   ptr_i        : port that wins when both request
//   en_i         : arbitration allowed this cycle
//   grant_o[1:0] : one-hot winner (all zero when disabled or nobody requests)
//   ptrNext_o    : pointer to load if the grant is taken (the non-winning port)

module rr_arbiter_2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       ptrNext_o
);

  // A lone requester wins regardless of the pointer; the pointer only breaks
  // ties. After any grant the pointer moves to the port that did not win.
  always_comb begin
    grant_o   = 2'b00;
    ptrNext_o = ptr_i;
    if (en_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
      if (grant_o != 2'b00) begin
        ptrNext_o = ~grant_o[1];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between the core datapath (port 0) and the
// address/branch unit (port 1). A request is accepted in IDLE, its operands
// are registered onto the ALU inputs, the ALU gets one cycle to settle, and the
// registered result is held for the granted port until it is consumed.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : alu_arbiter_if.slave (request/response handshakes + ALU hookup)

module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  arbState_e        state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             grantId_q, grantId_d;
  logic [WIDTH-1:0] aluA_q, aluA_d;
  logic [WIDTH-1:0] aluB_q, aluB_d;
  logic [OPW-1:0]   aluOp_q, aluOp_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [1:0] reqValid;
  logic [1:0] grant;
  logic       ptrNext;
  logic       arbEn;
  logic       winnerId;
  logic       grantedRspReady;

  // Arbitration is only live in IDLE; reset is folded in so no ready can leak
  // out combinationally while the block is held in reset.
  assign reqValid = {bus.req1_valid, bus.req0_valid};
  assign arbEn    = (state_q == ARB_IDLE) && reset;

  rr_arbiter_2 u_rr (
    .valid_i   (reqValid),
    .ptr_i     (ptr_q),
    .en_i      (arbEn),
    .grant_o   (grant),
    .ptrNext_o (ptrNext)
  );

  // Only the port that owns the pending response may release it.
  assign grantedRspReady = grantId_q ? bus.rsp1_ready : bus.rsp0_ready;

  // State register and datapath registers. Reset drops any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= 1'b0;
      grantId_q <= 1'b0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= ALU_AND;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grantId_q <= grantId_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluOp_q   <= aluOp_d;
      result_q  <= result_d;
    end
  end

  // Next-state logic: IDLE latches the winner's request, EXEC captures the ALU
  // output after its settling cycle, RESP waits for the owner to consume.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grantId_d = grantId_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluOp_d   = aluOp_q;
    result_d  = result_q;
    winnerId  = grant[1];

    unique case (state_q)
      ARB_IDLE: begin
        if (grant != 2'b00) begin
          aluA_d    = winnerId ? bus.req1_a  : bus.req0_a;
          aluB_d    = winnerId ? bus.req1_b  : bus.req0_b;
          aluOp_d   = winnerId ? bus.req1_op : bus.req0_op;
          grantId_d = winnerId;
          ptr_d     = ptrNext;
          state_d   = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        result_d = bus.alu_result;
        state_d  = ARB_RESP;
      end
      ARB_RESP: begin
        if (grantedRspReady) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp0_valid = (state_q == ARB_RESP) && !grantId_q;
  assign bus.rsp1_valid = (state_q == ARB_RESP) &&  grantId_q;
  assign bus.rsp_result = result_q;
  assign bus.alu_a      = aluA_q;
  assign bus.alu_b      = aluB_q;
  assign bus.alu_op     = aluOp_q;
  assign bus.busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a table of single-port transactions,
// hand-written multi-cycle sequences (reset abort, contention, backpressure,
// continuous alternation) and a randomized phase checked against a
// transaction-level reference model.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    int unsigned      port;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] expResult;
  } vector_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Reference ALU semantics, plain arithmetic on the operands.
  function automatic logic [WIDTH-1:0] aluRef(input logic [OPW-1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared ALU that sits next to the arbiter.
  always_comb bus.alu_result = aluRef(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic logic [1:0] oneHot(input int unsigned p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [OPW-1:0] pickOp();
    case ($urandom_range(0, 4))
      0:       return ALU_AND;
      1:       return ALU_OR;
      2:       return ALU_ADD;
      3:       return ALU_SUB;
      default: return ALU_XOR;
    endcase
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input int unsigned p, input logic v, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic driveRspReady(input int unsigned p, input logic r);
    if (p == 0) bus.rsp0_ready = r;
    else        bus.rsp1_ready = r;
  endtask

  task automatic clearInputs();
    driveReq(0, 1'b0, '0, '0, ALU_AND);
    driveReq(1, 1'b0, '0, '0, ALU_AND);
    driveRspReady(0, 1'b0);
    driveRspReady(1, 1'b0);
  endtask

  // One complete single-port transaction starting from IDLE.
  task automatic applyStimulus(input vector_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    driveReq(v.port, 1'b1, v.a, v.b, v.op);
    settle();
    checkOutput({tag, " ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, oneHot(v.port)});
    tick();
    driveReq(v.port, 1'b0, '0, '0, ALU_AND);
    settle();
    checkOutput({tag, " busy exec"}, {31'd0, bus.busy}, 32'd1);
    checkOutput({tag, " rsp exec"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput({tag, " alu_a"}, {16'd0, bus.alu_a}, {16'd0, v.a});
    checkOutput({tag, " alu_b"}, {16'd0, bus.alu_b}, {16'd0, v.b});
    checkOutput({tag, " alu_op"}, {28'd0, bus.alu_op}, {28'd0, v.op});
    tick();
    settle();
    checkOutput({tag, " rsp valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, {30'd0, oneHot(v.port)});
    checkOutput({tag, " result"}, {16'd0, bus.rsp_result}, {16'd0, v.expResult});
    checkOutput({tag, " ready resp"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    driveRspReady(v.port, 1'b1);
    tick();
    driveRspReady(v.port, 1'b0);
    settle();
    checkOutput({tag, " rsp done"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Bounded run time; reaching this means the sequence below got stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t          vecs[7];
    int               acceptCyc[$];
    int unsigned      acceptPort[$];
    logic [1:0]       rdy;
    logic             pendV[2];
    logic [WIDTH-1:0] pendA[2];
    logic [WIDTH-1:0] pendB[2];
    logic [OPW-1:0]   pendOp[2];
    logic             rspRdy[2];
    bit               inFlight;
    int unsigned      flPort;
    logic [WIDTH-1:0] flResult;
    int               flCyc;
    int unsigned      lastWinner;
    int unsigned      winner;
    logic [1:0]       expReady;
    logic [1:0]       expRsp;

    vecs[0] = '{0, 16'd15,     16'd30,     ALU_AND, 16'd14};
    vecs[1] = '{0, 16'd16,     16'd101,    ALU_ADD, 16'd117};
    vecs[2] = '{1, 16'd44,     16'd15,     ALU_SUB, 16'd29};
    vecs[3] = '{1, 16'h00F0,   16'h0F00,   ALU_OR,  16'h0FF0};
    vecs[4] = '{0, 16'hFFFF,   16'h00FF,   ALU_XOR, 16'hFF00};
    vecs[5] = '{1, 16'hFFFF,   16'h0002,   ALU_ADD, 16'h0001};
    vecs[6] = '{0, 16'h0000,   16'h0001,   ALU_SUB, 16'hFFFF};

    // Power-up reset and reset-state checks.
    clearInputs();
    #2 reset = 1'b0;
    tick();
    tick();
    settle();
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput("reset ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    checkOutput("reset alu_a", {16'd0, bus.alu_a}, 32'd0);
    checkOutput("reset alu_b", {16'd0, bus.alu_b}, 32'd0);
    checkOutput("reset alu_op", {28'd0, bus.alu_op}, {28'd0, ALU_AND});
    checkOutput("reset result", {16'd0, bus.rsp_result}, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] table of single-port transactions");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] reset during EXEC");
    driveReq(0, 1'b1, 16'd16, 16'd101, ALU_ADD);
    settle();
    checkOutput("abort ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    driveReq(0, 1'b0, '0, '0, ALU_AND);
    driveReq(1, 1'b1, 16'd44, 16'd15, ALU_SUB);
    reset = 1'b0;
    settle();
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput("abort ready gated", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    checkOutput("abort alu_a", {16'd0, bus.alu_a}, 32'd0);
    checkOutput("abort alu_op", {28'd0, bus.alu_op}, {28'd0, ALU_AND});
    driveReq(1, 1'b0, '0, '0, ALU_AND);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      checkOutput($sformatf("abort no rsp c%0d", i), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end

    $display("[TB] simultaneous requests after reset");
    driveReq(0, 1'b1, 16'd16, 16'd101, ALU_ADD);
    driveReq(1, 1'b1, 16'd44, 16'd15, ALU_SUB);
    settle();
    checkOutput("both first grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    driveReq(0, 1'b0, '0, '0, ALU_AND);
    settle();
    checkOutput("both no grant exec", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    settle();
    checkOutput("both rsp0", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    checkOutput("both result0", {16'd0, bus.rsp_result}, 32'd117);
    checkOutput("both no grant resp", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    driveRspReady(0, 1'b1);
    tick();
    driveRspReady(0, 1'b0);
    settle();
    checkOutput("both second grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    tick();
    driveReq(1, 1'b0, '0, '0, ALU_AND);
    tick();
    settle();
    checkOutput("both rsp1", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
    checkOutput("both result1", {16'd0, bus.rsp_result}, 32'd29);
    driveRspReady(1, 1'b1);
    tick();
    driveRspReady(1, 1'b0);
    settle();
    checkOutput("both idle", {31'd0, bus.busy}, 32'd0);

    $display("[TB] backpressure on port 1 with stray rsp0_ready");
    driveReq(1, 1'b1, 16'd44, 16'd15, ALU_SUB);
    settle();
    checkOutput("bp grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    tick();
    driveReq(1, 1'b0, '0, '0, ALU_AND);
    driveReq(0, 1'b1, 16'd15, 16'd30, ALU_AND);
    tick();
    for (int i = 0; i < 5; i++) begin
      driveRspReady(0, (i == 2));
      settle();
      checkOutput($sformatf("bp rsp held c%0d", i), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
      checkOutput($sformatf("bp result held c%0d", i), {16'd0, bus.rsp_result}, 32'd29);
      checkOutput($sformatf("bp no grant c%0d", i), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      tick();
    end
    driveRspReady(0, 1'b0);
    settle();
    checkOutput("bp rsp after pulse", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
    driveRspReady(1, 1'b1);
    tick();
    driveRspReady(1, 1'b0);
    settle();
    checkOutput("bp released", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    checkOutput("bp waiting p0 granted", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    driveReq(0, 1'b0, '0, '0, ALU_AND);
    tick();
    settle();
    checkOutput("bp p0 result", {16'd0, bus.rsp_result}, 32'd14);
    driveRspReady(0, 1'b1);
    tick();
    driveRspReady(0, 1'b0);

    // Port 0 won last, so with both continuously valid port 1 goes first.
    $display("[TB] continuous requests on both ports");
    driveReq(0, 1'b1, 16'd3, 16'd4, ALU_ADD);
    driveReq(1, 1'b1, 16'd9, 16'd2, ALU_SUB);
    driveRspReady(0, 1'b1);
    driveRspReady(1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      settle();
      rdy = {bus.req1_ready, bus.req0_ready};
      if (rdy == 2'b01) begin
        acceptCyc.push_back(c);
        acceptPort.push_back(0);
      end else if (rdy != 2'b00) begin
        acceptCyc.push_back(c);
        acceptPort.push_back((rdy == 2'b10) ? 1 : 3);
      end
      tick();
    end
    clearInputs();
    checkOutput("alt accept count", acceptCyc.size(), 32'd7);
    for (int k = 0; k < acceptPort.size(); k++) begin
      checkOutput($sformatf("alt port k%0d", k), acceptPort[k], (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        checkOutput($sformatf("alt spacing k%0d", k), acceptCyc[k] - acceptCyc[k-1], 32'd3);
      end
    end

    // Randomized traffic against a transaction-level model.
    $display("[TB] randomized traffic");
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      pendV[p] = 1'b0; pendA[p] = '0; pendB[p] = '0; pendOp[p] = ALU_AND; rspRdy[p] = 1'b0;
    end
    inFlight   = 1'b0;
    flPort     = 0;
    flResult   = '0;
    flCyc      = 0;
    lastWinner = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pendV[p] && $urandom_range(0, 2) == 0) begin
          pendV[p]  = 1'b1;
          pendA[p]  = 16'($urandom);
          pendB[p]  = 16'($urandom);
          pendOp[p] = pickOp();
        end
        rspRdy[p] = ($urandom_range(0, 1) == 1);
        driveReq(p, pendV[p], pendA[p], pendB[p], pendOp[p]);
        driveRspReady(p, rspRdy[p]);
      end
      settle();
      expReady = 2'b00;
      expRsp   = 2'b00;
      winner   = 0;
      if (!inFlight) begin
        if (pendV[0] && pendV[1]) winner = 1 - lastWinner;
        else if (pendV[1])        winner = 1;
        if (pendV[0] || pendV[1]) expReady = oneHot(winner);
      end else if (cyc >= flCyc + 2) begin
        expRsp = oneHot(flPort);
      end
      checkOutput($sformatf("rand ready c%0d", cyc), {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, expReady});
      checkOutput($sformatf("rand rsp c%0d", cyc), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, {30'd0, expRsp});
      if (expRsp != 2'b00) begin
        checkOutput($sformatf("rand result c%0d", cyc), {16'd0, bus.rsp_result}, {16'd0, flResult});
      end
      if (expReady != 2'b00) begin
        inFlight       = 1'b1;
        flPort         = winner;
        flResult       = aluRef(pendOp[winner], pendA[winner], pendB[winner]);
        flCyc          = cyc;
        lastWinner     = winner;
        pendV[winner]  = 1'b0;
      end else if (expRsp != 2'b00 && rspRdy[flPort]) begin
        inFlight = 1'b0;
      end
      tick();
    end
    clearInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
